// File: rtl/fma_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fma_share_arbiter
//  Description : Round-robin, burst-granular owner of one shared FMA array;
//                muxes the owner's operands in, routes tagged results back.
//  Revision    : 1.0 - initial release
// ============================================================================
module fma_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int BW_FP   = 17,
    parameter int LANES   = 8,
    parameter int BW_MODE = 5,
    parameter int FMA_LAT = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0]                 req,
    input  logic [N_REQ-1:0]                 op_vld,
    input  logic [N_REQ*LANES*BW_MODE-1:0]   op_mode,
    input  logic [N_REQ*LANES*BW_FP-1:0]     op_a,
    input  logic [N_REQ*LANES*BW_FP-1:0]     op_b,
    input  logic [N_REQ*LANES*BW_FP-1:0]     op_c,
    output logic [N_REQ-1:0]                 gnt,
    output logic                             fma_vld,
    output logic [LANES*BW_MODE-1:0]         fma_mode,
    output logic [LANES*BW_FP-1:0]           fma_a,
    output logic [LANES*BW_FP-1:0]           fma_b,
    output logic [LANES*BW_FP-1:0]           fma_c,
    input  logic [LANES*BW_FP-1:0]           fma_out,
    output logic [N_REQ-1:0]                 rsp_vld,
    output logic [LANES*BW_FP-1:0]           rsp_data,
    output logic                             err_ill_issue
);

    localparam int C_IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int C_VW  = LANES * BW_FP;
    localparam int C_MW  = LANES * BW_MODE;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OWNED = 1'b1;

    logic [0:0]                   r_state, w_state_nxt;
    logic [N_REQ-1:0]             r_gnt, w_gnt_nxt;
    logic [C_IDW-1:0]             r_owner, w_owner_nxt;
    logic [C_IDW-1:0]             r_rr_ptr, w_rr_nxt;
    logic                         r_err;
    logic [FMA_LAT-1:0]           r_tag_vld;
    logic [FMA_LAT-1:0][C_IDW-1:0] r_tag_id;

    logic                         w_win_found;
    logic [C_IDW-1:0]             w_win_id;
    logic [N_REQ-1:0]             w_win_onehot;
    logic [C_IDW-1:0]             w_win_next;
    logic                         w_accept;

    // Cyclic first-set search starting at the round-robin pointer.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_win_found && req[idx]) begin
                w_win_found = 1'b1;
                w_win_id    = C_IDW'(idx);
            end
        end
    end

    assign w_win_onehot = N_REQ'(1) << w_win_id;
    assign w_win_next   = (w_win_id == C_IDW'(N_REQ - 1)) ? '0 : w_win_id + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = S_OWNED;
                    w_gnt_nxt   = w_win_onehot;
                    w_owner_nxt = w_win_id;
                    w_rr_nxt    = w_win_next;
                end
            end
            S_OWNED: begin
                // Owner has released: req[owner] is low, so the search skips it.
                if (!req[r_owner]) begin
                    if (w_win_found) begin
                        w_gnt_nxt   = w_win_onehot;
                        w_owner_nxt = w_win_id;
                        w_rr_nxt    = w_win_next;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    assign w_accept = |(r_gnt & op_vld);

    // Only the granted requester's slice reaches the array; idle inputs are zero.
    always_comb begin
        fma_mode = '0;
        fma_a    = '0;
        fma_b    = '0;
        fma_c    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i] && op_vld[i]) begin
                fma_mode = op_mode[i*C_MW +: C_MW];
                fma_a    = op_a[i*C_VW +: C_VW];
                fma_b    = op_b[i*C_VW +: C_VW];
                fma_c    = op_c[i*C_VW +: C_VW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_err        <= r_err | (|(op_vld & ~r_gnt));
            r_tag_vld[0] <= w_accept;
            r_tag_id[0]  <= r_owner;
            for (int s = 1; s < FMA_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    generate
        for (genvar k = 0; k < N_REQ; k++) begin : g_rsp
            assign rsp_vld[k] = r_tag_vld[FMA_LAT-1] && (r_tag_id[FMA_LAT-1] == C_IDW'(k));
        end
    endgenerate

    assign gnt           = r_gnt;
    assign fma_vld       = w_accept;
    assign rsp_data      = fma_out;
    assign err_ill_issue = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fma_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fma_share_arbiter
//  Description : Directed + randomized bench for fma_share_arbiter against a
//                cycle-level ownership/in-flight model with an a*b+c FMA model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fma_share_arbiter;

    localparam int N   = 4;
    localparam int FP  = 17;
    localparam int L   = 8;
    localparam int M   = 5;
    localparam int LAT = 2;
    localparam int VW  = L * FP;
    localparam int MW  = L * M;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req, op_vld;
    logic [N*MW-1:0]   op_mode;
    logic [N*VW-1:0]   op_a, op_b, op_c;
    logic [N-1:0]      gnt;
    logic              fma_vld;
    logic [MW-1:0]     fma_mode;
    logic [VW-1:0]     fma_a, fma_b, fma_c, fma_out;
    logic [N-1:0]      rsp_vld;
    logic [VW-1:0]     rsp_data;
    logic              err_ill_issue;

    fma_share_arbiter #(
        .N_REQ(N), .BW_FP(FP), .LANES(L), .BW_MODE(M), .FMA_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .op_vld(op_vld), .op_mode(op_mode),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .gnt(gnt), .fma_vld(fma_vld),
        .fma_mode(fma_mode), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
        .fma_out(fma_out), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
        .err_ill_issue(err_ill_issue)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        int            id;
        logic [VW-1:0] data;
    } inflight_t;

    inflight_t     q[$];
    logic [VW-1:0] fpipe [LAT];
    int            m_owner, m_ptr, cyc;
    logic          m_err;
    int            n_cmp = 0, n_bad = 0;

    int            own_cnt, prev_owner;
    logic [N-1:0]  prev_gnt, r_req, t_vld;
    int            order[$];
    int            exp_ord[5] = '{0, 1, 2, 3, 0};

    function automatic logic [VW-1:0] fma_calc(input logic [VW-1:0] a, b, c);
        logic [VW-1:0] r;
        logic [2*FP:0] t;
        r = '0;
        for (int l = 0; l < L; l++) begin
            t = a[l*FP +: FP] * b[l*FP +: FP] + c[l*FP +: FP];
            r[l*FP +: FP] = t[FP-1:0];
        end
        return r;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] m_mask();
        return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance model and FMA pipe.
    task automatic tick(input logic [N-1:0] t_req, input logic [N-1:0] v, input logic t_rst);
        logic [N-1:0]  e_gnt, e_rsp;
        logic          e_acc;
        logic [VW-1:0] e_a, e_b, e_c, e_data, res;
        logic [MW-1:0] e_mode;
        rst = t_rst;
        req = t_req;
        op_vld = v;
        repeat (17) begin
            op_a = (op_a << 32) | (N*VW)'($urandom);
            op_b = (op_b << 32) | (N*VW)'($urandom);
            op_c = (op_c << 32) | (N*VW)'($urandom);
        end
        repeat (5) op_mode = (op_mode << 32) | (N*MW)'($urandom);
        #1;
        e_gnt = m_mask();
        e_acc = (m_owner >= 0) && v[m_owner];
        e_a = '0; e_b = '0; e_c = '0; e_mode = '0;
        if (e_acc) begin
            e_a    = op_a[m_owner*VW +: VW];
            e_b    = op_b[m_owner*VW +: VW];
            e_c    = op_c[m_owner*VW +: VW];
            e_mode = op_mode[m_owner*MW +: MW];
        end
        e_rsp = '0;
        e_data = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e_rsp  = N'(1) << q[0].id;
            e_data = q[0].data;
            void'(q.pop_front());
        end
        check("gnt", 256'(gnt), 256'(e_gnt));
        check("fma_vld", 256'(fma_vld), 256'(e_acc));
        check("fma_mode", 256'(fma_mode), 256'(e_mode));
        check("fma_a", 256'(fma_a), 256'(e_a));
        check("fma_b", 256'(fma_b), 256'(e_b));
        check("fma_c", 256'(fma_c), 256'(e_c));
        check("rsp_vld", 256'(rsp_vld), 256'(e_rsp));
        check("err", 256'(err_ill_issue), 256'(m_err));
        if (e_rsp != '0) check("rsp_data", 256'(rsp_data), 256'(e_data));
        res = fma_calc(fma_a, fma_b, fma_c);
        if (t_rst) begin
            m_owner = -1; m_ptr = 0; m_err = 1'b0;
            q.delete();
        end else begin
            if ((v & ~e_gnt) != '0) m_err = 1'b1;
            if (e_acc) q.push_back('{cyc + LAT, m_owner, fma_calc(e_a, e_b, e_c)});
            if (m_owner < 0 || !t_req[m_owner]) begin
                m_owner = pick(t_req, m_ptr);
                if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
            end
        end
        @(posedge clk);
        for (int s = LAT - 1; s > 0; s--) fpipe[s] = fpipe[s-1];
        fpipe[0] = res;
        fma_out = fpipe[LAT-1];
        cyc++;
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; op_vld = '0; op_mode = '0;
        op_a = '0; op_b = '0; op_c = '0; fma_out = '0;
        for (int s = 0; s < LAT; s++) fpipe[s] = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0;
        check("rst_gnt", 256'(gnt), 256'(0));
        check("rst_rsp_vld", 256'(rsp_vld), 256'(0));
        check("rst_err", 256'(err_ill_issue), 256'(0));
        check("rst_fma_vld", 256'(fma_vld), 256'(0));
        m_owner = -1; m_ptr = 0; m_err = 1'b0;

        // Single-requester burst
        tick(4'b0001, 4'b0000, 1'b0);
        check("t1_gnt_c1", 256'(gnt), 256'(4'b0001));
        tick(4'b0001, 4'b0000, 1'b0);
        repeat (4) tick(4'b0001, 4'b0001, 1'b0);
        repeat (2) tick(4'b0001, 4'b0000, 1'b0);
        repeat (2) tick(4'b0000, 4'b0000, 1'b0);

        // Two requesters, handover on release, then pointer-driven pick
        repeat (6) tick(4'b0011, 4'b0000, 1'b0);
        tick(4'b0010, 4'b0000, 1'b0);
        check("t2_gnt_1", 256'(gnt), 256'(4'b0010));
        repeat (2) tick(4'b0010, 4'b0010, 1'b0);
        tick(4'b0111, 4'b0010, 1'b0);
        tick(4'b0101, 4'b0000, 1'b0);
        check("t2_gnt_2", 256'(gnt), 256'(4'b0100));
        repeat (2) tick(4'b0000, 4'b0000, 1'b0);

        // Owner issues on its release cycle; new owner issues immediately
        repeat (2) tick(4'b0011, 4'b0001, 1'b0);
        tick(4'b0010, 4'b0001, 1'b0);
        tick(4'b0010, 4'b0010, 1'b0);
        repeat (3) tick(4'b0010, 4'b0000, 1'b0);
        repeat (2) tick(4'b0000, 4'b0000, 1'b0);

        // Illegal issue from a non-owner
        tick(4'b0001, 4'b0000, 1'b0);
        tick(4'b0001, 4'b0100, 1'b0);
        check("t4_err_set", 256'(err_ill_issue), 256'(1));
        repeat (3) tick(4'b0000, 4'b0000, 1'b0);
        check("t4_err_sticky", 256'(err_ill_issue), 256'(1));

        // Reset with results in flight
        tick(4'b0001, 4'b0000, 1'b0);
        repeat (2) tick(4'b0001, 4'b0001, 1'b0);
        tick(4'b0001, 4'b0000, 1'b1);
        check("t5_gnt", 256'(gnt), 256'(0));
        repeat (4) tick(4'b0000, 4'b0000, 1'b0);
        check("t5_rsp_vld", 256'(rsp_vld), 256'(0));

        // All requesters held, each releases after 3 cycles of ownership
        own_cnt = 0; prev_owner = -1; prev_gnt = '0;
        for (int c = 0; c < 24; c++) begin
            r_req = 4'b1111;
            if (m_owner >= 0 && own_cnt >= 3) r_req[m_owner] = 1'b0;
            tick(r_req, m_mask(), 1'b0);
            if (gnt != '0 && gnt != prev_gnt)
                for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
            prev_gnt = gnt;
            own_cnt = (m_owner == prev_owner) ? own_cnt + 1 : 1;
            prev_owner = m_owner;
        end
        check("t6_order_len", 256'(order.size() >= 5), 256'(1));
        for (int i = 0; i < 5 && i < order.size(); i++)
            check("t6_order", 256'(order[i]), 256'(exp_ord[i]));
        repeat (3) tick(4'b0000, 4'b0000, 1'b0);

        // Randomized bursts with occasional illegal issues and resets
        r_req = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) r_req[i] = ~r_req[i];
            t_vld = m_mask() & N'($urandom);
            if ($urandom_range(0, 63) == 0) t_vld = t_vld | N'($urandom);
            tick(r_req, t_vld, ($urandom_range(0, 199) == 0));
        end
        repeat (LAT + 2) tick(4'b0000, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
